// File: rtl/pixel_scan_counter_pkg.sv
// Shared GPU compositing constants, scan FSM states and a counter-width helper.
package pixel_scan_counter_pkg;

  localparam int unsigned H_RES_DEF      = 1920;
  localparam int unsigned V_RES_DEF      = 1080;
  localparam int unsigned NUM_LAYERS_DEF = 32;
  localparam int unsigned FCNT_W_DEF     = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_scan_counter_wrap.sv
// Modulo-N counter with synchronous clear and a wrap carry for chaining.
module wrap_counter
  import pixel_scan_counter_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = cnt_w(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_max_c;

  assign at_max_c = (count_q == W'(N - 1));

  // Clear outranks inc; wrap is by explicit compare, never by overflow.
  always_comb begin
    count_d = count_q;
    wrap_c  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      if (at_max_c) begin
        count_d = '0;
        wrap_c  = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pixel_scan_counter.sv
// Frame scan-position generator: layer/x/y counters chained by wrap carries,
// IDLE/SCAN frame FSM, line/frame pulses and a completed-frame counter.
module pixel_scan_counter
  import pixel_scan_counter_pkg::*;
#(
  parameter int unsigned H_RES      = H_RES_DEF,
  parameter int unsigned V_RES      = V_RES_DEF,
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int unsigned CONTINUOUS = 0,
  parameter int unsigned FCNT_W     = FCNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           restart,
  input  logic                           next_layer,
  input  logic                           next_pixel,
  output logic [cnt_w(NUM_LAYERS)-1:0]   layer,
  output logic [cnt_w(H_RES)-1:0]        x,
  output logic [cnt_w(V_RES)-1:0]        y,
  output logic                           busy,
  output logic                           last_layer,
  output logic                           line_end,
  output logic                           frame_done,
  output logic [FCNT_W-1:0]              frame_count
);

  localparam int unsigned LAYER_W = cnt_w(NUM_LAYERS);

  scan_state_e       state_q, state_d;
  logic              line_end_q, line_end_d;
  logic              frame_done_q, frame_done_d;
  logic [FCNT_W-1:0] frame_count_q, frame_count_d;

  logic scan_c, arm_c, zero_c;
  logic layer_clear_c, layer_inc_c, layer_wrap_c;
  logic x_inc_c, x_wrap_c, y_wrap_c;

  // restart outranks every strobe and start; strobes only count in SCAN.
  assign scan_c        = (state_q == SCAN) && !restart;
  assign arm_c         = (state_q == IDLE) && start && !restart;
  assign zero_c        = restart || arm_c;
  assign layer_clear_c = zero_c || (scan_c && next_pixel);
  assign layer_inc_c   = scan_c && next_layer;
  assign x_inc_c       = scan_c && (next_pixel || layer_wrap_c);

  wrap_counter #(.N(NUM_LAYERS)) u_layer (
    .clk    (clk),
    .reset  (reset),
    .clear  (layer_clear_c),
    .inc    (layer_inc_c),
    .count  (layer),
    .wrap_c (layer_wrap_c)
  );

  wrap_counter #(.N(H_RES)) u_x (
    .clk    (clk),
    .reset  (reset),
    .clear  (zero_c),
    .inc    (x_inc_c),
    .count  (x),
    .wrap_c (x_wrap_c)
  );

  wrap_counter #(.N(V_RES)) u_y (
    .clk    (clk),
    .reset  (reset),
    .clear  (zero_c),
    .inc    (x_wrap_c),
    .count  (y),
    .wrap_c (y_wrap_c)
  );

  always_comb begin
    state_d       = state_q;
    line_end_d    = x_wrap_c;
    frame_done_d  = y_wrap_c;
    frame_count_d = frame_count_q;
    if (y_wrap_c) frame_count_d = frame_count_q + FCNT_W'(1);
    if (restart) begin
      state_d = SCAN;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = SCAN;
        SCAN:    if (y_wrap_c && (CONTINUOUS == 0)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      line_end_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      line_end_q    <= line_end_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign busy        = (state_q == SCAN);
  assign last_layer  = (layer == LAYER_W'(NUM_LAYERS - 1));
  assign line_end    = line_end_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_scan_counter.sv
// Scoreboard bench: one-shot and continuous instances share stimulus and are
// checked against a linear pixel-index reference model.
module tb_pixel_scan_counter;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned L  = 2;
  localparam int unsigned FW = 8;

  logic clk = 1'b0;
  logic reset, start, restart, next_layer, next_pixel;

  logic [0:0]    layer0, layer1;
  logic [1:0]    x0, x1, y0, y1;
  logic          busy0, busy1, ll0, ll1, le0, le1, fd0, fd1;
  logic [FW-1:0] fc0, fc1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int l; int x; int y; int busy; int ll; int le; int fd; int fc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference state: layer, linear pixel index p = y*H + x, busy, frame count.
  int m_l[2], m_p[2], m_fc[2], m_busy[2];

  always #5 clk = ~clk;

  pixel_scan_counter #(.H_RES(H), .V_RES(V), .NUM_LAYERS(L), .CONTINUOUS(0), .FCNT_W(FW)) dut0 (
    .clk(clk), .reset(reset), .start(start), .restart(restart),
    .next_layer(next_layer), .next_pixel(next_pixel),
    .layer(layer0), .x(x0), .y(y0), .busy(busy0), .last_layer(ll0),
    .line_end(le0), .frame_done(fd0), .frame_count(fc0));

  pixel_scan_counter #(.H_RES(H), .V_RES(V), .NUM_LAYERS(L), .CONTINUOUS(1), .FCNT_W(FW)) dut1 (
    .clk(clk), .reset(reset), .start(start), .restart(restart),
    .next_layer(next_layer), .next_pixel(next_pixel),
    .layer(layer1), .x(x1), .y(y1), .busy(busy1), .last_layer(ll1),
    .line_end(le1), .frame_done(fd1), .frame_count(fc1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input exp_t a, input exp_t e);
    string p;
    p = $sformatf("dut%0d.", k);
    chk({p, "layer"},       a.l,    e.l);
    chk({p, "x"},           a.x,    e.x);
    chk({p, "y"},           a.y,    e.y);
    chk({p, "busy"},        a.busy, e.busy);
    chk({p, "last_layer"},  a.ll,   e.ll);
    chk({p, "line_end"},    a.le,   e.le);
    chk({p, "frame_done"},  a.fd,   e.fd);
    chk({p, "frame_count"}, a.fc,   e.fc);
  endtask

  function automatic exp_t actual(input int k);
    exp_t a;
    if (k == 0) begin
      a.l = int'(layer0); a.x = int'(x0); a.y = int'(y0); a.busy = int'(busy0);
      a.ll = int'(ll0); a.le = int'(le0); a.fd = int'(fd0); a.fc = int'(fc0);
    end else begin
      a.l = int'(layer1); a.x = int'(x1); a.y = int'(y1); a.busy = int'(busy1);
      a.ll = int'(ll1); a.le = int'(le1); a.fd = int'(fd1); a.fc = int'(fc1);
    end
    return a;
  endfunction

  // Expected outputs after the next clock edge, from the behavioural rules.
  task automatic model_step(input int k, input bit rn, input bit st, input bit rs,
                            input bit nl, input bit np, input bit cont, output exp_t e);
    int le, fd;
    le = 0;
    fd = 0;
    if (!rn) begin
      m_l[k] = 0; m_p[k] = 0; m_busy[k] = 0; m_fc[k] = 0;
    end else if (rs) begin
      m_l[k] = 0; m_p[k] = 0; m_busy[k] = 1;
    end else if (m_busy[k] == 0) begin
      if (st) begin
        m_l[k] = 0; m_p[k] = 0; m_busy[k] = 1;
      end
    end else if (np || (nl && m_l[k] == L - 1)) begin
      m_l[k] = 0;
      m_p[k] = m_p[k] + 1;
      if (m_p[k] == H * V) begin
        m_p[k] = 0;
        fd = 1;
        m_fc[k] = (m_fc[k] + 1) % (1 << FW);
        m_busy[k] = cont ? 1 : 0;
      end
      if (m_p[k] % H == 0) le = 1;
    end else if (nl) begin
      m_l[k] = m_l[k] + 1;
    end
    e.l = m_l[k]; e.x = m_p[k] % H; e.y = m_p[k] / H; e.busy = m_busy[k];
    e.ll = (m_l[k] == L - 1) ? 1 : 0; e.le = le; e.fd = fd; e.fc = m_fc[k];
  endtask

  task automatic drive(input bit rn, input bit st, input bit rs, input bit nl, input bit np);
    exp_t e0, e1;
    @(negedge clk);
    reset = rn; start = st; restart = rs; next_layer = nl; next_pixel = np;
    model_step(0, rn, st, rs, nl, np, 1'b0, e0);
    model_step(1, rn, st, rs, nl, np, 1'b1, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  // Monitor: every edge produces one observable output set per instance.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) cmp(0, actual(0), q0.pop_front());
    if (q1.size() > 0) cmp(1, actual(1), q1.pop_front());
  end

  initial begin
    reset = 1'b0; start = 1'b0; restart = 1'b0; next_layer = 1'b0; next_pixel = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_l[k] = 0; m_p[k] = 0; m_fc[k] = 0; m_busy[k] = 0;
    end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    // Start, then layer stepping into a pixel advance.
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    // Held next_pixel across a line wrap.
    drive(1, 0, 1, 0, 0);
    repeat (4) drive(1, 0, 0, 0, 1);
    // Both strobes together at x=2.
    drive(1, 0, 1, 0, 0);
    repeat (2) drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 1, 1);
    // One full frame, then 24 more pixels; idle strobes on the one-shot copy.
    drive(1, 0, 1, 0, 0);
    repeat (12) drive(1, 0, 0, 0, 1);
    repeat (24) drive(1, 0, 0, 1, 1);
    // Restart mid-frame at x=2,y=1.
    drive(1, 0, 1, 0, 0);
    repeat (6) drive(1, 0, 0, 0, 1);
    drive(1, 0, 1, 1, 1);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3));
    end
    // Asynchronous reset between edges must clear outputs before the next edge.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst.x0",     int'(x0),     0);
    chk("async_rst.y0",     int'(y0),     0);
    chk("async_rst.layer1", int'(layer1), 0);
    chk("async_rst.busy1",  int'(busy1),  0);
    chk("async_rst.fc1",    int'(fc1),    0);
    chk("async_rst.fc0",    int'(fc0),    0);
    drive(0, 1, 0, 1, 1);
    drive(1, 1, 0, 0, 0);
    repeat (20) drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_scan_counter.md
# pixel_scan_counter

Parametrised scan-position generator for the GPU engine's compositing read path. It tracks the current layer, x and y coordinate to fetch from RAM, advancing on per-layer and per-pixel completion strobes. It adds a frame-level state machine, start/restart control, wrap and end-of-frame flags, a frame counter, and single-shot or continuous mode. Resolution and layer count are set by parameters. Sits between the engine sequencer (strobe source) and the pixel-RAM address generator (consumer of layer/x/y).

## Interface
- H_RES, 1920, active pixels per line (>=2)
- V_RES, 1080, lines per frame (>=2)
- NUM_LAYERS, 32, layers composited per pixel (>=1)
- CONTINUOUS, 0, 1 = re-arm automatically after frame end; 0 = return to IDLE
- FCNT_W, 8, frame counter width
- clk  in  1  master clock, all logic on rising edge
- reset  in  1  asynchronous, active-low (0 = reset, 1 = run)
- start  in  1  begin a frame from IDLE; ignored outside IDLE
- restart  in  1  synchronous: zero layer/x/y and enter SCAN from any state
- next_layer  in  1  current layer done; one increment per high cycle
- next_pixel  in  1  current pixel done (all remaining layers skipped); one increment per high cycle
- layer  out  LAYER_W = max(1,$clog2(NUM_LAYERS))  current layer
- x  out  X_W = $clog2(H_RES)  current column
- y  out  Y_W = $clog2(V_RES)  current line
- busy  out  1  high in SCAN
- last_layer  out  1  layer == NUM_LAYERS-1 (combinational from registers)
- line_end  out  1  one-cycle pulse when x wraps to 0
- frame_done  out  1  one-cycle pulse at frame completion
- frame_count  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W

## Operation
- States: IDLE, SCAN. Reset -> IDLE; layer=x=y=0, busy=0, line_end=0, frame_done=0, frame_count=0.
- IDLE: strobes ignored, counters hold. start=1 -> SCAN with counters at 0.
- SCAN, "pixel advance" occurs when next_pixel=1, or when next_layer=1 and layer==NUM_LAYERS-1. On pixel advance:
  - layer<=0.
  - x<=x+1. If x==H_RES-1: x<=0, line_end pulse, and y advances.
  - y<=y+1. If y==V_RES-1: y<=0, frame_done pulse, frame_count+1, and the next state is SCAN if CONTINUOUS else IDLE.
- SCAN, next_layer=1 without pixel advance: layer<=layer+1.
- next_pixel and next_layer both high: treated as a single pixel advance, never two increments.
- restart takes priority over all strobes and start: counters to 0, state SCAN, no frame_done pulse, frame_count unchanged.
- Strobes are level-sampled on each edge. A strobe held high N cycles produces N increments; no single-cycle restriction on the source.
- Counters never hold values >= their limit. Arithmetic wraps only by explicit compare, never by natural overflow.
- NUM_LAYERS=1: every next_layer is a pixel advance; layer is constant 0.

## Timing
- Strobe sampled at edge k; the new layer/x/y are visible after edge k, i.e. 1-cycle latency.
- line_end and frame_done are registered. They are high for exactly the one cycle in which x/y already show 0.
- busy falls in the same cycle frame_done is high (CONTINUOUS=0).
- start in IDLE -> busy=1 after the next edge. The first strobe is accepted on the following edge.
- Reset deassertion: synchronise externally. Reset assertion mid-frame clears everything immediately, without waiting for a clock.

## Structure
- Shared GPU package holds the default H_RES/V_RES/NUM_LAYERS constants and the state enum (IDLE, SCAN).
- One sub-module, wrap_counter: parametrised modulo-N counter with inc, clear and wrap-pulse output. It is instantiated three times (layer, x, y), chained by wrap outputs. The top holds the FSM, the priority logic and frame_count.

## Test plan
Use H_RES=4, V_RES=3, NUM_LAYERS=2.
- Reset then start, one next_layer -> layer=1. Second next_layer -> layer=0, x=1.
- next_pixel held 4 cycles from x=0,y=0 -> x 1,2,3,0. line_end high only on the x=0 cycle; y=1.
- Both strobes high at layer=0,x=2 -> x=3, layer=0, exactly one increment.
- 12 next_pixel pulses, CONTINUOUS=0 -> frame_done one cycle, frame_count=1, busy=0. Further strobes leave x/y at 0.
- CONTINUOUS=1, 24 pulses -> two frame_done pulses, frame_count=2, busy stays 1.
- restart at x=2,y=1 -> 0,0,0 next cycle, no frame_done. Async reset asserted mid-cycle -> all outputs 0 before the next edge.
